// File: rtl/matrix_pkg.sv
// Shared types and index helpers for the matrix loader / multiplier pair.
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } load_state_t;

  // Width of an element index into an n x n matrix.
  function automatic int idx_w(input int n);
    return $clog2(n * n);
  endfunction

  // Low bit of flattened element k; identical to the multiplier's slicing.
  function automatic int slice_lo(input int k, input int bits);
    return k * bits;
  endfunction

endpackage

// File: rtl/matrix_stream_loader.sv
// Assembles a serial element stream into flattened A then B operand buses
// and holds them, flagged valid, until the consumer acknowledges.
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int BITS = 8,
  parameter int N = 8,
  localparam int IDX_W = idx_w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [BITS-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mats_ack,
  output logic [N*N*BITS-1:0]   A_out,
  output logic [N*N*BITS-1:0]   B_out,
  output logic                  mats_valid,
  output logic [IDX_W-1:0]      load_idx,
  output logic                  load_b
);

  localparam int NN = N * N;

  load_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             xfer;
  logic             last;

  assign in_ready = (state != FULL);
  assign xfer     = in_valid && in_ready;
  assign last     = (idx == IDX_W'(NN - 1));
  assign load_b   = (state == LOAD_B);
  assign load_idx = idx;

  // Next state and index; clr overrides both transfer and acknowledge.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (clr) begin
      state_nxt = LOAD_A;
      idx_nxt   = '0;
    end else begin
      case (state)
        LOAD_A: begin
          if (xfer) begin
            if (last) begin
              state_nxt = LOAD_B;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            if (last) begin
              state_nxt = FULL;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        FULL: begin
          if (mats_ack) state_nxt = LOAD_A;
        end
        default: begin
          state_nxt = LOAD_A;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Control registers; mats_valid is registered from the next state so it
  // tracks FULL exactly without a combinational path to the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_A;
      idx        <= '0;
      mats_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      mats_valid <= (state_nxt == FULL);
    end
  end

  // Operand storage: only the slice decoded from idx is written on a
  // transfer, so untouched slices keep their previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A_out <= '0;
      B_out <= '0;
    end else if (xfer && !clr) begin
      for (int k = 0; k < NN; k++) begin
        if (idx == IDX_W'(k)) begin
          if (state == LOAD_B) B_out[slice_lo(k, BITS) +: BITS] <= in_data;
          else                 A_out[slice_lo(k, BITS) +: BITS] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: an N=2 and an N=8 instance checked against
// an element-count based reference model.
module tb_matrix_stream_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Unit 0: N=2
  logic         clr0, iv0, ack0, ir0, mv0, lb0;
  logic [7:0]   d0;
  logic [1:0]   li0;
  logic [31:0]  a0, b0;
  // Unit 1: N=8
  logic         clr1, iv1, ack1, ir1, mv1, lb1;
  logic [7:0]   d1;
  logic [5:0]   li1;
  logic [511:0] a1, b1;

  matrix_stream_loader #(.BITS(8), .N(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr0), .in_data(d0), .in_valid(iv0),
    .in_ready(ir0), .mats_ack(ack0), .A_out(a0), .B_out(b0),
    .mats_valid(mv0), .load_idx(li0), .load_b(lb0)
  );

  matrix_stream_loader #(.BITS(8), .N(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr1), .in_data(d1), .in_valid(iv1),
    .in_ready(ir1), .mats_ack(ack1), .A_out(a1), .B_out(b1),
    .mats_valid(mv1), .load_idx(li1), .load_b(lb1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: elements received so far and whether the pair is full.
  logic [7:0] ma [2][64];
  logic [7:0] mb [2][64];
  int         cnt [2];
  bit         full [2];
  int         nn [2] = '{4, 64};

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 64; k++) begin
        ma[u][k] = 8'h00;
        mb[u][k] = 8'h00;
      end
      cnt[u]  = 0;
      full[u] = 1'b0;
    end
  endtask

  task automatic model_edge(input int u, input logic v, input logic [7:0] d,
                            input logic c, input logic k);
    if (c) begin
      cnt[u]  = 0;
      full[u] = 1'b0;
    end else if (full[u]) begin
      if (k) full[u] = 1'b0;
    end else if (v) begin
      if (cnt[u] < nn[u]) ma[u][cnt[u]] = d;
      else                mb[u][cnt[u] - nn[u]] = d;
      cnt[u]++;
      if (cnt[u] == 2 * nn[u]) begin
        cnt[u]  = 0;
        full[u] = 1'b1;
      end
    end
  endtask

  task automatic check_outs(input int u);
    logic [511:0] ea, eb, ga, gb;
    logic gir, gmv, glb;
    int   gli;
    ea = '0;
    eb = '0;
    for (int k = 0; k < nn[u]; k++) begin
      ea[k*8 +: 8] = ma[u][k];
      eb[k*8 +: 8] = mb[u][k];
    end
    ga = '0;
    gb = '0;
    if (u == 0) begin
      ga[31:0] = a0; gb[31:0] = b0;
      gir = ir0; gmv = mv0; glb = lb0; gli = int'(li0);
    end else begin
      ga = a1; gb = b1;
      gir = ir1; gmv = mv1; glb = lb1; gli = int'(li1);
    end
    chk($sformatf("u%0d_in_ready", u),   512'(gir), 512'(!full[u]));
    chk($sformatf("u%0d_mats_valid", u), 512'(gmv), 512'(full[u]));
    chk($sformatf("u%0d_load_b", u),     512'(glb), 512'(cnt[u] >= nn[u]));
    chk($sformatf("u%0d_load_idx", u),   512'(gli), 512'(cnt[u] % nn[u]));
    chk($sformatf("u%0d_A_out", u),      ga, ea);
    chk($sformatf("u%0d_B_out", u),      gb, eb);
  endtask

  task automatic step(input int u, input logic v, input logic [7:0] d,
                      input logic c, input logic k);
    if (u == 0) begin iv0 = v; d0 = d; clr0 = c; ack0 = k; end
    else        begin iv1 = v; d1 = d; clr1 = c; ack1 = k; end
    @(posedge clk);
    #1;
    model_edge(u, v, d, c, k);
    if (u == 0) begin iv0 = 1'b0; clr0 = 1'b0; ack0 = 1'b0; end
    else        begin iv1 = 1'b0; clr1 = 1'b0; ack1 = 1'b0; end
    check_outs(u);
  endtask

  // Reset with valid data offered; nothing may be captured while rst is high.
  task automatic do_reset();
    rst = 1'b1;
    iv0 = 1'b1; d0 = 8'hAA; clr0 = 1'b0; ack0 = 1'b0;
    iv1 = 1'b1; d1 = 8'hAA; clr1 = 1'b0; ack1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    iv0 = 1'b0;
    iv1 = 1'b0;
    model_reset();
    check_outs(0);
    check_outs(1);
  endtask

  initial begin
    int rises;
    logic prev_mv;
    logic [7:0] c_el, a_el, b_el;
    int acc;

    do_reset();

    // Reset mid-load
    step(0, 1'b1, 8'h31, 1'b0, 1'b0);
    step(0, 1'b1, 8'h32, 1'b0, 1'b0);
    step(0, 1'b1, 8'h33, 1'b0, 1'b0);
    do_reset();
    chk("rst_mid_A", 512'(a0), 512'(32'h0));
    chk("rst_mid_idx", 512'(li0), 512'(0));
    chk("rst_mid_ready", 512'(ir0), 512'(1));

    // Full back-to-back load
    for (int i = 1; i <= 8; i++) begin
      step(0, 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 7) chk("full_mv_early", 512'(mv0), 512'(0));
    end
    chk("full_A", 512'(a0), 512'(32'h04030201));
    chk("full_B", 512'(b0), 512'(32'h08070605));
    chk("full_mv", 512'(mv0), 512'(1));
    chk("full_ready", 512'(ir0), 512'(0));

    // Hold while FULL with data offered, then ack together with valid
    for (int i = 0; i < 10; i++) step(0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("hold_A", 512'(a0), 512'(32'h04030201));
    chk("hold_B", 512'(b0), 512'(32'h08070605));
    step(0, 1'b1, 8'hFF, 1'b0, 1'b1);
    chk("ack_A_unchanged", 512'(a0), 512'(32'h04030201));
    chk("ack_idx", 512'(li0), 512'(0));
    step(0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("post_ack_A0", 512'(a0), 512'(32'h040302FF));

    // clr during LOAD_B idx 1 with a simultaneous transfer
    step(0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(0, 1'b1, 8'h12, 1'b0, 1'b0);
    step(0, 1'b1, 8'h13, 1'b0, 1'b0);
    step(0, 1'b1, 8'h21, 1'b0, 1'b0);
    chk("pre_clr_load_b", 512'(lb0), 512'(1));
    step(0, 1'b1, 8'h99, 1'b1, 1'b0);
    chk("clr_B_kept", 512'(b0), 512'(32'h08070621));
    chk("clr_A_kept", 512'(a0), 512'(32'h131211FF));
    chk("clr_load_b", 512'(lb0), 512'(0));
    chk("clr_idx", 512'(li0), 512'(0));

    // Randomized traffic including stray acks, clr and gaps
    for (int i = 0; i < 300; i++) begin
      step(0, 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0));
    end

    // Multiplier chain: identity A times arbitrary B must give B
    step(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(0, 1'b1, 8'h01, 1'b0, 1'b0);
    step(0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(0, 1'b1, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("mul_mv", 512'(mv0), 512'(1));
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int k = 0; k < 2; k++) begin
          a_el = a0[(2*i+k)*8 +: 8];
          b_el = b0[(2*k+j)*8 +: 8];
          acc += int'(a_el) * int'(b_el);
        end
        c_el = 8'(acc);
        chk($sformatf("mul_c_%0d%0d", i, j), 512'(c_el), 512'(mb[0][2*i+j]));
      end
    end

    // Gapped stream on N=8: 128 elements with in_valid every other cycle
    rises   = 0;
    prev_mv = mv1;
    for (int i = 0; i < 266; i++) begin
      step(1, 1'((i % 2 == 0) && (i < 256)), 8'($urandom), 1'b0, 1'b0);
      if (mv1 && !prev_mv) rises++;
      prev_mv = mv1;
    end
    chk("gap_mv_once", 512'(rises), 512'(1));
    chk("gap_mv_high", 512'(mv1), 512'(1));
    step(1, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1, 1'b1, 8'h5A, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
